// File: rtl/fm_ch_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_ch_seq_if : operator-job bus from channel scheduler to op pipeline |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fm_ch_seq_if;
    logic       op_valid;
    logic       op_ready;
    logic [4:0] op_ch;
    logic       op_idx;
    logic       op_alg;
    logic [2:0] op_fb;
    logic [2:0] op_block;
    logic [9:0] op_fnum;
    logic       op_keyon;
    logic       op_keyoff;

    modport master (
        output op_valid, op_ch, op_idx, op_alg, op_fb, op_block, op_fnum,
               op_keyon, op_keyoff,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_ch, op_idx, op_alg, op_fb, op_block, op_fnum,
               op_keyon, op_keyoff,
        output op_ready
    );
endinterface
`default_nettype wire

// File: rtl/fm_ch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_ch_seq : per-sample channel scheduler, two operator jobs/channel  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fm_ch_seq #(
    parameter int NUM_CH = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    output logic        busy,
    output logic        sample_done,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [4:0]  ch_sel,
    input  logic        ch_kon,
    input  logic        ch_alg,
    input  logic [2:0]  ch_fb,
    input  logic [2:0]  ch_block,
    input  logic [9:0]  ch_fnum,
    fm_ch_seq_if.master op
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OP0   = 2'd2,
        S_OP1   = 2'd3
    } state_t;

    localparam logic [4:0] C_LAST_CH = 5'(NUM_CH - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_ch;
    logic              r_kon;
    logic              r_alg;
    logic [2:0]        r_fb;
    logic [2:0]        r_block;
    logic [9:0]        r_fnum;
    logic              r_keyon;
    logic              r_keyoff;
    logic              r_sample_done;
    logic              r_overrun;
    logic [NUM_CH-1:0] r_kon_prev;
    logic              w_prev_kon;
    logic              w_last;

    assign w_last = (r_ch == C_LAST_CH);

    // Mux avoids an out-of-range index when NUM_CH is not a power of two
    always_comb begin
        w_prev_kon = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch == 5'(i)) w_prev_kon = r_kon_prev[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_tick) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_OP0;
            S_OP0:   if (op.op_ready) w_state_next = S_OP1;
            S_OP1:   if (op.op_ready) w_state_next = w_last ? S_IDLE : S_FETCH;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch          <= '0;
            r_kon         <= 1'b0;
            r_alg         <= 1'b0;
            r_fb          <= '0;
            r_block       <= '0;
            r_fnum        <= '0;
            r_keyon       <= 1'b0;
            r_keyoff      <= 1'b0;
            r_sample_done <= 1'b0;
            r_overrun     <= 1'b0;
            r_kon_prev    <= '0;
        end else begin
            r_sample_done <= 1'b0;
            // A tick arriving while busy beats a simultaneous clear
            if (sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
            else if (overrun_clr)                   r_overrun <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (sample_tick) r_ch <= '0;
                end
                S_FETCH: begin
                    r_kon    <= ch_kon;
                    r_alg    <= ch_alg;
                    r_fb     <= ch_fb;
                    r_block  <= ch_block;
                    r_fnum   <= ch_fnum;
                    r_keyon  <= ch_kon & ~w_prev_kon;
                    r_keyoff <= ~ch_kon & w_prev_kon;
                end
                S_OP1: begin
                    if (op.op_ready) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (r_ch == 5'(i)) r_kon_prev[i] <= r_kon;
                        end
                        if (w_last) begin
                            r_ch          <= '0;
                            r_sample_done <= 1'b1;
                        end else begin
                            r_ch <= r_ch + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign sample_done = r_sample_done;
    assign overrun     = r_overrun;
    assign ch_sel      = r_ch;

    assign op.op_valid  = (r_state == S_OP0) || (r_state == S_OP1);
    assign op.op_idx    = (r_state == S_OP1);
    assign op.op_ch     = r_ch;
    assign op.op_alg    = r_alg;
    assign op.op_fb     = r_fb;
    assign op.op_block  = r_block;
    assign op.op_fnum   = r_fnum;
    assign op.op_keyon  = r_keyon;
    assign op.op_keyoff = r_keyoff;

endmodule
`default_nettype wire

// File: tb/tb_fm_ch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fm_ch_seq : directed self-checking bench for fm_ch_seq            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fm_ch_seq;

    localparam int NCH = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       busy, sample_done, overrun;
    logic [4:0] ch_sel;
    logic       ch_kon, ch_alg;
    logic [2:0] ch_fb, ch_block;
    logic [9:0] ch_fnum;

    logic       m_kon   [32];
    logic       m_alg   [32];
    logic [2:0] m_fb    [32];
    logic [2:0] m_block [32];
    logic [9:0] m_fnum  [32];

    int total = 0;
    int bad   = 0;

    int         q_ch   [$];
    int         q_idx  [$];
    logic       q_kon  [$];
    logic       q_koff [$];
    logic [9:0] q_fnum [$];
    logic       q_alg  [$];
    logic [2:0] q_fb   [$];
    logic [2:0] q_blk  [$];
    int         done_cyc;
    int         first_valid_cyc;
    int         stab_err;

    fm_ch_seq_if bus ();

    fm_ch_seq #(.NUM_CH(NCH)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .busy        (busy),
        .sample_done (sample_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .ch_sel      (ch_sel),
        .ch_kon      (ch_kon),
        .ch_alg      (ch_alg),
        .ch_fb       (ch_fb),
        .ch_block    (ch_block),
        .ch_fnum     (ch_fnum),
        .op          (bus)
    );

    always #5 clk = ~clk;

    assign ch_kon   = m_kon[ch_sel];
    assign ch_alg   = m_alg[ch_sel];
    assign ch_fb    = m_fb[ch_sel];
    assign ch_block = m_block[ch_sel];
    assign ch_fnum  = m_fnum[ch_sel];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a pass with a tick in the current cycle (cycle 0) and records every accepted job
    task automatic run_pass(input bit rnd, input int xtick, input int clr, input bit wr);
        logic [24:0] prev_snap;
        logic [24:0] snap;
        bit          prev_stall;
        bit          wrote;
        bit          rdy;
        q_ch.delete(); q_idx.delete(); q_kon.delete(); q_koff.delete();
        q_fnum.delete(); q_alg.delete(); q_fb.delete(); q_blk.delete();
        done_cyc = -1; first_valid_cyc = -1; stab_err = 0;
        prev_stall = 1'b0; wrote = 1'b0; prev_snap = '0;
        bus.op_ready = 1'b1;
        sample_tick  = 1'b1;
        for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
            step();
            sample_tick = 1'b0;
            overrun_clr = 1'b0;
            snap = {bus.op_ch, bus.op_idx, bus.op_alg, bus.op_fb, bus.op_block,
                    bus.op_fnum, bus.op_keyon, bus.op_keyoff};
            if (sample_done) done_cyc = cyc;
            if (bus.op_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (!bus.op_valid || snap != prev_snap)) stab_err++;
            if (wr && !wrote && bus.op_valid && bus.op_idx && ch_sel == 5'd1) begin
                m_fnum[2] = 10'h3A5;
                m_fnum[0] = 10'h15A;
                wrote = 1'b1;
            end
            rdy = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            bus.op_ready = rdy;
            if (bus.op_valid && rdy) begin
                q_ch.push_back(int'(bus.op_ch));
                q_idx.push_back(int'(bus.op_idx));
                q_kon.push_back(bus.op_keyon);
                q_koff.push_back(bus.op_keyoff);
                q_fnum.push_back(bus.op_fnum);
                q_alg.push_back(bus.op_alg);
                q_fb.push_back(bus.op_fb);
                q_blk.push_back(bus.op_block);
            end
            prev_stall = bus.op_valid && !rdy;
            prev_snap  = snap;
            if (cyc == xtick) sample_tick = 1'b1;
            if (cyc == clr)   overrun_clr = 1'b1;
        end
        bus.op_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++;
        if ({busy, sample_done, overrun, bus.op_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: busy/done/ovr/valid=%b required 0000",
                     {busy, sample_done, overrun, bus.op_valid});
        end
        total++;
        if ({ch_sel, bus.op_ch, bus.op_fnum, bus.op_keyon} !== 21'd0) begin
            bad++;
            $display("FAIL reset_data: ch_sel=%0d op_ch=%0d fnum=%0h keyon=%b required all 0",
                     ch_sel, bus.op_ch, bus.op_fnum, bus.op_keyon);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_pass();
        int errs;
        run_pass(1'b0, -1, -1, 1'b0);
        total++;
        if (done_cyc !== 55) begin
            bad++;
            $display("FAIL basic_done_cycle: got %0d required 55", done_cyc);
        end
        total++;
        if (first_valid_cyc !== 2) begin
            bad++;
            $display("FAIL basic_first_valid: got %0d required 2", first_valid_cyc);
        end
        total++;
        if (q_ch.size() !== 36) begin
            bad++;
            $display("FAIL basic_job_count: got %0d required 36", q_ch.size());
        end
        errs = 0;
        for (int j = 0; j < q_ch.size() && j < 36; j++) begin
            if (q_ch[j] != j / 2 || q_idx[j] != j % 2 || q_fnum[j] != m_fnum[j/2] ||
                q_alg[j] != m_alg[j/2] || q_fb[j] != m_fb[j/2] || q_blk[j] != m_block[j/2])
                errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL basic_job_content: %0d bad jobs required 0", errs);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_at_done: got %b required 0", busy);
        end
        step();
        total++;
        if (sample_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse: got %b required 0 one cycle later", sample_done);
        end
    endtask

    task automatic test_keyon();
        int errs;
        m_kon[5] = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            if (p == 3) m_kon[5] = 1'b0;
            run_pass(1'b0, -1, -1, 1'b0);
            errs = 0;
            for (int j = 0; j < q_ch.size(); j++) begin
                if (q_kon[j]  !== ((p == 1) && q_ch[j] == 5)) errs++;
                if (q_koff[j] !== ((p == 3) && q_ch[j] == 5)) errs++;
            end
            total++;
            if (errs !== 0 || q_ch.size() !== 36) begin
                bad++;
                $display("FAIL keyon_pass%0d: %0d flag errors, %0d jobs, required 0 and 36",
                         p, errs, q_ch.size());
            end
        end
    endtask

    task automatic test_ready_random();
        int errs;
        run_pass(1'b1, -1, -1, 1'b0);
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL rnd_timeout: got no sample_done required one within 3000 cycles");
        end
        total++;
        if (stab_err !== 0) begin
            bad++;
            $display("FAIL rnd_stability: %0d changes while stalled required 0", stab_err);
        end
        errs = 0;
        for (int j = 0; j < q_ch.size(); j++)
            if (q_ch[j] != j / 2 || q_idx[j] != j % 2 || q_fnum[j] != m_fnum[j/2]) errs++;
        total++;
        if (errs !== 0 || q_ch.size() !== 36) begin
            bad++;
            $display("FAIL rnd_order: %0d bad jobs of %0d required 0 of 36", errs, q_ch.size());
        end
    endtask

    task automatic test_overrun();
        run_pass(1'b0, 10, -1, 1'b0);
        total++;
        if (overrun !== 1'b1 || done_cyc !== 55 || q_ch.size() !== 36) begin
            bad++;
            $display("FAIL overrun_set: ovr=%b done=%0d jobs=%0d required 1/55/36",
                     overrun, done_cyc, q_ch.size());
        end
        run_pass(1'b0, 20, 20, 1'b0);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set_wins: got %b required 1", overrun);
        end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
    endtask

    task automatic test_attr_write();
        logic [9:0] old0;
        old0 = m_fnum[0];
        run_pass(1'b0, -1, -1, 1'b1);
        total++;
        if (q_ch.size() !== 36 || q_fnum[4] !== 10'h3A5 || q_fnum[5] !== 10'h3A5) begin
            bad++;
            $display("FAIL write_ahead: ch2 fnum %0h/%0h required 3a5", q_fnum[4], q_fnum[5]);
        end
        total++;
        if (q_fnum[0] !== old0) begin
            bad++;
            $display("FAIL write_behind_now: ch0 fnum %0h required %0h", q_fnum[0], old0);
        end
        run_pass(1'b0, -1, -1, 1'b0);
        total++;
        if (q_fnum[0] !== 10'h15A) begin
            bad++;
            $display("FAIL write_behind_next: ch0 fnum %0h required 15a", q_fnum[0]);
        end
    endtask

    task automatic test_reset_mid();
        int found;
        int sd_seen;
        int errs;
        m_kon[3] = 1'b1;
        m_kon[9] = 1'b1;
        run_pass(1'b0, -1, -1, 1'b0);
        sample_tick = 1'b1;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            step();
            sample_tick = 1'b0;
            if (bus.op_valid && !bus.op_idx && ch_sel == 5'd7) found = 1;
        end
        total++;
        if (found !== 1) begin
            bad++;
            $display("FAIL rstmid_reach_ch7: got found=%0d required 1", found);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (bus.op_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_abort: valid=%b busy=%b required 0 0", bus.op_valid, busy);
        end
        sd_seen = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (sample_done) sd_seen++;
        end
        total++;
        if (sd_seen !== 0) begin
            bad++;
            $display("FAIL rstmid_no_done: %0d sample_done pulses required 0", sd_seen);
        end
        run_pass(1'b0, -1, -1, 1'b0);
        errs = 0;
        for (int j = 0; j < q_ch.size(); j++)
            if (q_kon[j] !== (q_ch[j] == 3 || q_ch[j] == 9)) errs++;
        total++;
        if (errs !== 0 || q_ch.size() !== 36 || q_ch[0] !== 0) begin
            bad++;
            $display("FAIL rstmid_keyon: %0d flag errors, %0d jobs required 0, 36", errs, q_ch.size());
        end
    endtask

    task automatic test_back_to_back();
        int fin;
        run_pass(1'b0, -1, -1, 1'b0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        total++;
        if (busy !== 1'b1 || overrun !== 1'b0 || ch_sel !== 5'd0) begin
            bad++;
            $display("FAIL b2b_restart: busy=%b ovr=%b ch_sel=%0d required 1 0 0",
                     busy, overrun, ch_sel);
        end
        fin = -1;
        for (int c = 2; c <= 200 && fin < 0; c++) begin
            step();
            if (sample_done) fin = c;
        end
        total++;
        if (fin !== 55) begin
            bad++;
            $display("FAIL b2b_done_cycle: got %0d required 55", fin);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_kon[i]   = 1'b0;
            m_alg[i]   = i[0];
            m_fb[i]    = 3'(i % 8);
            m_block[i] = 3'((i + 3) % 8);
            m_fnum[i]  = 10'(i * 37 + 5);
        end
        bus.op_ready = 1'b1;
        test_reset();
        test_basic_pass();
        test_keyon();
        test_ready_random();
        test_overrun();
        test_attr_write();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
